// File: rtl/bin_pkg.sv
// Shared constants and FSM state encoding for the BIN binary-search engine.
package bin_pkg;

    localparam int    BIN_W     = 20;
    localparam int    IDX_W     = 12;
    localparam int    DEPTH     = 2638;
    localparam string INIT_FILE = "./bindb/bins.mif";

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        READ = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/bin_search_if.sv
// Request/result bundle between BIN entry, the search engine and brand lookup.
interface bin_search_if #(
    parameter int BIN_W = bin_pkg::BIN_W,
    parameter int IDX_W = bin_pkg::IDX_W
);

    logic             start;
    logic [BIN_W-1:0] query_bin;
    logic [IDX_W-1:0] found_index;
    logic             binary_search_done;
    logic             binary_search_found;
    logic             busy;

    modport master (
        output start, query_bin,
        input  found_index, binary_search_done, binary_search_found, busy
    );

    modport slave (
        input  start, query_bin,
        output found_index, binary_search_done, binary_search_found, busy
    );

endinterface

// File: rtl/bin_rom.sv
// Sorted BIN table: synchronous-read ROM, one cycle of latency, output not reset
// so the array maps onto a block RAM. Contents come from the init file.
module bin_rom #(
    parameter int    DEPTH     = bin_pkg::DEPTH,
    parameter int    BIN_W     = bin_pkg::BIN_W,
    parameter int    IDX_W     = bin_pkg::IDX_W,
    parameter string INIT_FILE = bin_pkg::INIT_FILE
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    output logic [BIN_W-1:0] q
);

    (* ram_init_file = INIT_FILE *) logic [BIN_W-1:0] mem [DEPTH] = '{default: '0};

    // Registered read port; address is always within 0..DEPTH-1 from the engine.
    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/bin_search.sv
// Binary search of a query BIN over the sorted ROM. Each probe is three cycles
// (CALC mid, READ rom, CMP); the result triple is held in DONE until restarted.
module bin_search #(
    parameter int    DEPTH     = bin_pkg::DEPTH,
    parameter int    BIN_W     = bin_pkg::BIN_W,
    parameter int    IDX_W     = bin_pkg::IDX_W,
    parameter string INIT_FILE = bin_pkg::INIT_FILE
) (
    input logic         CLOCK_50,
    input logic         resetn,
    bin_search_if.slave bus
);

    import bin_pkg::*;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] query_q, query_d;
    logic [IDX_W:0]   low_q, low_d;      // one extra bit: low may reach DEPTH
    logic [IDX_W:0]   high_q, high_d;
    logic [IDX_W-1:0] mid_q, mid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             found_q, found_d;

    logic [BIN_W-1:0] rom_q;
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   mid_inc;
    logic [IDX_W:0]   mid_dec;
    logic             accept;
    logic             rom_eq;
    logic             rom_lt;
    logic             miss_hi;
    logic             miss_lo;

    bin_rom #(
        .DEPTH     (DEPTH),
        .BIN_W     (BIN_W),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (CLOCK_50),
        .addr (mid_q),
        .q    (rom_q)
    );

    assign accept  = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign sum     = low_q + high_q;
    assign mid_inc = {1'b0, mid_q} + 1'b1;
    assign mid_dec = {1'b0, mid_q} - 1'b1;
    assign rom_eq  = (rom_q == query_q);
    assign rom_lt  = (rom_q < query_q);
    assign miss_hi = (mid_inc > high_q);
    // mid==0 is tested first so high never wraps below zero.
    assign miss_lo = (mid_q == '0) || (mid_dec < low_q);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: starts outside IDLE/DONE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = CALC;
            CALC:       state_d = READ;
            READ:       state_d = CMP;
            CMP: begin
                if (rom_eq)      state_d = DONE;
                else if (rom_lt) state_d = miss_hi ? DONE : CALC;
                else             state_d = miss_lo ? DONE : CALC;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Search bounds, probe index and result registers.
    always_comb begin
        query_d = query_q;
        low_d   = low_q;
        high_d  = high_q;
        mid_d   = mid_q;
        idx_d   = idx_q;
        done_d  = done_q;
        found_d = found_q;
        if (accept) begin
            query_d = bus.query_bin;
            low_d   = '0;
            high_d  = (IDX_W+1)'(DEPTH - 1);
            idx_d   = '0;
            done_d  = 1'b0;
            found_d = 1'b0;
        end
        case (state_q)
            CALC: mid_d = sum[IDX_W:1];
            CMP: begin
                if (rom_eq) begin
                    idx_d   = mid_q;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                end else if (rom_lt) begin
                    low_d = mid_inc;
                    if (miss_hi) done_d = 1'b1;
                end else begin
                    if (miss_lo) done_d = 1'b1;
                    else         high_d = mid_dec;
                end
            end
            default: ;
        endcase
    end

    // Datapath flops; everything visible downstream clears on reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            query_q <= '0;
            low_q   <= '0;
            high_q  <= '0;
            mid_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
        end else begin
            query_q <= query_d;
            low_q   <= low_d;
            high_q  <= high_d;
            mid_q   <= mid_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            found_q <= found_d;
        end
    end

    // Outputs: result straight from flops, busy decoded from state.
    always_comb begin
        bus.found_index         = idx_q;
        bus.binary_search_done  = done_q;
        bus.binary_search_found = found_q;
        bus.busy                = (state_q == CALC) || (state_q == READ) || (state_q == CMP);
    end

endmodule

// File: tb/tb_bin_search.sv
// Directed bench for bin_search: ROM holds 100000 + 7*i.
module tb_bin_search;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    bin_search_if bus ();

    bin_search dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int done, input int found, input int idx, input int busy);
        chk({tag, "_done"},  int'(bus.binary_search_done),  done);
        chk({tag, "_found"}, int'(bus.binary_search_found), found);
        chk({tag, "_idx"},   int'(bus.found_index),         idx);
        chk({tag, "_busy"},  int'(bus.busy),                busy);
    endtask

    // Launch one search, wait (bounded) for done, check result and latency.
    task automatic run_search(input string tag, input int q, input int exp_found,
                              input int exp_idx, input int exact);
        int n;
        @(negedge CLOCK_50);
        bus.start     = 1'b1;
        bus.query_bin = 20'(q);
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0;
        chk({tag, "_acc_busy"}, int'(bus.busy), 1);
        chk({tag, "_acc_done"}, int'(bus.binary_search_done), 0);
        n = 0;
        while (!bus.binary_search_done && n < 40) begin
            @(posedge CLOCK_50);
            n++;
            #1;
        end
        chk_out(tag, 1, exp_found, exp_idx, 0);
        if (exact >= 0) chk({tag, "_lat"}, n, exact);
        else            chk({tag, "_lat_le36"}, int'(n <= 36), 1);
    endtask

    initial begin
        int n;
        bus.start     = 1'b0;
        bus.query_bin = '0;
        #1;
        for (int i = 0; i < 2638; i++) dut.u_rom.mem[i] = 20'(100000 + 7 * i);
        #30;
        chk_out("reset", 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        run_search("mid",     109226, 1, 1318, 3);
        run_search("first",   100000, 1, 0,    -1);
        run_search("last",    118459, 1, 2637, -1);
        run_search("below",   99999,  0, 0,    -1);
        run_search("above",   118460, 0, 0,    -1);
        run_search("between", 100003, 0, 0,    -1);
        run_search("restart", 100007, 1, 1,    -1);

        // Second start during READ must be ignored.
        @(negedge CLOCK_50);
        bus.start     = 1'b1;
        bus.query_bin = 20'd100000;
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.start     = 1'b1;
        bus.query_bin = 20'd118459;
        @(posedge CLOCK_50);
        #1;
        bus.start     = 1'b0;
        bus.query_bin = '0;
        n = 0;
        while (!bus.binary_search_done && n < 40) begin
            @(posedge CLOCK_50);
            n++;
            #1;
        end
        chk_out("ignore", 1, 1, 0, 0);
        for (int c = 0; c < 20; c++) begin
            @(posedge CLOCK_50);
            #1;
            chk_out("hold", 1, 1, 0, 0);
        end

        // Asynchronous reset while holding a result.
        #3;
        resetn = 1'b0;
        #1;
        chk_out("rst_done", 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // Asynchronous reset during READ.
        @(negedge CLOCK_50);
        bus.start     = 1'b1;
        bus.query_bin = 20'd109226;
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0;
        @(posedge CLOCK_50);
        #2;
        resetn = 1'b0;
        #1;
        chk_out("rst_read", 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        run_search("after_rst", 109226, 1, 1318, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_search.md
# bin_search

Binary-search engine that locates a 6-digit card BIN in a sorted on-chip ROM of 2638 entries. It produces the `found_index` / `binary_search_done` / `binary_search_found` triple consumed by the card-brand lookup stage. It sits between keypad/BIN entry and the brand/bank lookups. It holds its result stable until the next search is started.

## Interface
- `DEPTH`, 2638: number of ROM entries, sorted strictly ascending.
- `BIN_W`, 20: BIN width, binary-encoded decimal value 0..999999.
- `IDX_W`, 12: index width; DEPTH-1 must fit.
- `INIT_FILE`, "./bindb/bins.mif": ROM init file.
- Reset is `resetn`, asynchronous, active-low. The clock is `CLOCK_50`.
- `CLOCK_50`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled request; accepted only in IDLE or DONE.
- `query_bin`  in  BIN_W  BIN to find; latched on the accepting edge.
- `found_index`  out  IDX_W  matching ROM index; 0 when not found.
- `binary_search_done`  out  1  level; high in DONE until the next accepted start.
- `binary_search_found`  out  1  valid while done is high; 1 means a match.
- `busy`  out  1  high in CALC/READ/CMP.

## Operation
- States: IDLE, CALC, READ, CMP, DONE. Reset state is IDLE.
- IDLE/DONE with `start`=1:
  - latch `query_bin`
  - set low=0, high=DEPTH-1
  - clear done, found and found_index
  - go to CALC.
- CALC: mid <= (low+high)>>1, go to READ. low and high are IDX_W+1 bits, so the sum cannot overflow.
- READ: rom_q <= rom[mid] (synchronous ROM, 1-cycle), go to CMP.
- CMP:
  - rom_q == query: found_index<=mid, found<=1, done<=1, go to DONE.
  - rom_q < query: low<=mid+1. If mid+1 > high, the result is not found (go to DONE, found=0); otherwise go to CALC.
  - rom_q > query: if mid==0 or mid-1 < low, the result is not found; else high<=mid-1 and go to CALC. mid==0 must never underflow high.
- Compare is unsigned over BIN_W bits.
- DONE: hold found_index, found and done until `start` is accepted. Downstream reads `found_index` continuously and delays done by 2 cycles, so all three must stay stable.
- `start` in CALC/READ/CMP is ignored and not queued.
- `start` held high continuously in DONE relaunches a search every completion. done then drops for the duration of each search.
- Asynchronous reset in any state: IDLE immediately, all outputs 0, query/low/high/mid cleared.

## Timing
- Reset values: `found_index`=0, `binary_search_done`=0, `binary_search_found`=0, `busy`=0.
- Each probe costs 3 cycles: CALC, READ, CMP.
- Take E0 as the edge that accepts `start`:
  - `busy` is high after E0.
  - A 1st-probe hit has done=1 after E3.
  - A hit or miss on probe k has done=1 after edge E(3k).
- Worst case is 12 probes (ceil(log2(2639))), so done is high no later than after E36.
- done, found and found_index all update on the same edge. `busy` falls on that same edge.
- A re-accepting `start` in DONE clears done on the accepting edge.

## Structure
- Shared package `bin_pkg`:
  - BIN_W, IDX_W, DEPTH
  - state enum/localparams (IDLE=0, CALC=1, READ=2, CMP=3, DONE=4)
  - INIT_FILE path constant.
- Sub-module `bin_rom`: DEPTH x BIN_W synchronous-read ROM with the `ram_init_file` attribute, 1-cycle latency, no reset on the data output. It must infer block RAM.
- Top: FSM, low/high/mid/query registers and output registers.

## Test plan
- Bench ROM is loaded with rom[i] = 100000 + 7*i.
- Query 109226 (rom[1318]) -> done=1, found=1, found_index=1318 exactly 3 cycles after the start edge; `busy` low on that same edge.
- Query 100000 (rom[0]) and 118459 (rom[2637]) -> found=1, found_index=0 and 2637 respectively; done within 36 cycles.
- Query 99999 (below min) and 118460 (above max) -> done=1, found=0, found_index=0; no index underflow or overflow.
- Query 100003 (between entries) -> found=0 within 36 cycles. Then pulse start with 100007 -> done drops on the accepting edge, then done=1, found=1, found_index=1.
- Start pulsed again mid-search with a different query -> ignored; the original result is reported. Outputs are held stable for 20 cycles in DONE with `start`=0.
- `resetn` asserted during READ -> all outputs 0 immediately; after release, `start` with 109226 behaves exactly as the first scenario.
